// File: rtl/frame_uart_serializer.sv
// Frame-to-byte serializer: latches a 64 x 18-bit filtered frame on the rising edge
// of inValid and streams it as a header byte plus 3 bytes/sample over valid/ready.

module frame_uart_serializer_lane #(
  parameter int SAMPLE_W = 18
) (
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic [2:0][7:0]     o_bytes
);
  logic [23:0] w_ext;

  // Sign-extend to 24 bits; index 0 is the first (most significant) byte on the wire.
  assign w_ext      = {{(24-SAMPLE_W){i_sample[SAMPLE_W-1]}}, i_sample};
  assign o_bytes[0] = w_ext[23:16];
  assign o_bytes[1] = w_ext[15:8];
  assign o_bytes[2] = w_ext[7:0];
endmodule

module frame_uart_serializer #(
  parameter int          N_SAMPLES = 64,
  parameter int          SAMPLE_W  = 18,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_SAMPLES*SAMPLE_W-1:0] inFrame,
  input  logic                          inValid,
  output logic [7:0]                    outByte,
  output logic                          outValid,
  input  logic                          outReady,
  output logic                          busy,
  output logic                          frameDone,
  output logic                          overrun
);
  localparam int SIDX_W = $clog2(N_SAMPLES);

  typedef enum logic [1:0] {IDLE, HDR, SAMP} state_t;

  state_t                             r_state, w_state_nxt;
  logic [N_SAMPLES-1:0][SAMPLE_W-1:0] r_frame;
  logic [N_SAMPLES-1:0][2:0][7:0]     w_lane_bytes;
  logic                               r_in_d;
  logic [SIDX_W-1:0]                  r_sidx, w_sidx_nxt, w_adv_sidx;
  logic [1:0]                         r_bidx, w_bidx_nxt, w_adv_bidx;
  logic [7:0]                         r_byte, w_byte_nxt, w_adv_byte;
  logic [2:0][7:0]                    w_adv_lane;
  logic                               r_vld, w_vld_nxt;
  logic                               r_busy, w_busy_nxt;
  logic                               r_done, w_done_nxt;
  logic                               r_ovr, w_ovr_nxt;
  logic                               w_start, w_xfer, w_last, w_load;

  genvar g;
  generate
    for (g = 0; g < N_SAMPLES; g++) begin : g_lane
      frame_uart_serializer_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
        .i_sample (r_frame[g]),
        .o_bytes  (w_lane_bytes[g])
      );
    end
  endgenerate

  assign w_start = inValid & ~r_in_d;
  assign w_xfer  = r_vld & outReady;

  // Stream position following the byte currently on the wire.
  always_comb begin
    w_last     = (r_bidx == 2'd2) && (r_sidx == SIDX_W'(N_SAMPLES-1));
    w_adv_bidx = (r_bidx == 2'd2) ? 2'd0 : r_bidx + 2'd1;
    w_adv_sidx = (r_bidx == 2'd2) ? r_sidx + SIDX_W'(1) : r_sidx;
  end

  assign w_adv_lane = w_lane_bytes[w_adv_sidx];

  always_comb begin
    case (w_adv_bidx)
      2'd0:    w_adv_byte = w_adv_lane[0];
      2'd1:    w_adv_byte = w_adv_lane[1];
      default: w_adv_byte = w_adv_lane[2];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sidx_nxt  = r_sidx;
    w_bidx_nxt  = r_bidx;
    w_byte_nxt  = r_byte;
    w_vld_nxt   = r_vld;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_ovr_nxt   = r_ovr;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_load      = 1'b1;
          w_byte_nxt  = HEADER;
          w_vld_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = HDR;
        end
      end
      HDR: begin
        if (w_start) w_ovr_nxt = 1'b1;
        if (w_xfer) begin
          w_byte_nxt  = w_lane_bytes[0][0];
          w_sidx_nxt  = '0;
          w_bidx_nxt  = '0;
          w_state_nxt = SAMP;
        end
      end
      SAMP: begin
        // A start edge on the final-transfer cycle still counts as an overrun.
        if (w_start) w_ovr_nxt = 1'b1;
        if (w_xfer) begin
          if (w_last) begin
            w_vld_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_sidx_nxt  = '0;
            w_bidx_nxt  = '0;
            w_state_nxt = IDLE;
          end else begin
            w_sidx_nxt  = w_adv_sidx;
            w_bidx_nxt  = w_adv_bidx;
            w_byte_nxt  = w_adv_byte;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_in_d  <= 1'b0;
      r_sidx  <= '0;
      r_bidx  <= '0;
      r_byte  <= '0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_in_d  <= inValid;
      r_sidx  <= w_sidx_nxt;
      r_bidx  <= w_bidx_nxt;
      r_byte  <= w_byte_nxt;
      r_vld   <= w_vld_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // Frame storage needs no reset: it is only read after a start has loaded it.
  always_ff @(posedge clk) begin
    if (w_load) r_frame <= inFrame;
  end

  assign outByte   = r_byte;
  assign outValid  = r_vld;
  assign busy      = r_busy;
  assign frameDone = r_done;
  assign overrun   = r_ovr;
endmodule

// File: tb/tb_frame_uart_serializer.sv
// Directed sequence with randomized frames/back-pressure, checked against a byte-queue model.

module tb_frame_uart_serializer;
  logic          clk = 1'b0;
  logic          rst;
  logic [1151:0] inFrame;
  logic          inValid;
  logic [7:0]    outByte;
  logic          outValid;
  logic          outReady;
  logic          busy;
  logic          frameDone;
  logic          overrun;

  int            n_tot = 0;
  int            n_fail = 0;
  logic [17:0]   smp [64];
  logic [7:0]    expq [$];

  frame_uart_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .inFrame   (inFrame),
    .inValid   (inValid),
    .outByte   (outByte),
    .outValid  (outValid),
    .outReady  (outReady),
    .busy      (busy),
    .frameDone (frameDone),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: header, then each sample as a 24-bit two's-complement number, high byte first.
  task automatic build_exp();
    int signed sv;
    expq.delete();
    expq.push_back(8'hA5);
    for (int i = 0; i < 64; i++) begin
      sv = $signed(smp[i]);
      expq.push_back(8'((sv >>> 16) & 255));
      expq.push_back(8'((sv >>> 8) & 255));
      expq.push_back(8'(sv & 255));
    end
  endtask

  task automatic pack();
    for (int i = 0; i < 64; i++) inFrame[18*i +: 18] = smp[i];
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 64; i++) smp[i] = 18'($urandom);
  endtask

  task automatic start_frame(input bit predrop);
    if (predrop) begin
      inValid = 1'b0;
      @(negedge clk);
    end
    pack();
    inValid = 1'b1;
    @(negedge clk);
    chk("start_valid", outValid, 1);
    chk("start_hdr", outByte, 8'hA5);
    chk("start_busy", busy, 1);
  endtask

  // Drives outReady each cycle and scores every transfer against the model queue.
  task automatic run_frame(input int pct, input int ovr_at, input int rst_at,
                           output int nx, output int c_first, output int c_last,
                           output bit got_done);
    int         cyc = 0;
    int         ph = 0;
    bit         hold = 1'b0;
    logic [7:0] prev = '0;
    logic [7:0] e;
    nx = 0; c_first = -1; c_last = -1; got_done = 1'b0;
    while (cyc < 4000) begin
      if (frameDone) begin
        got_done = 1'b1;
        chk("done_vld_low", outValid, 0);
        chk("done_busy_low", busy, 0);
        break;
      end
      if (hold) chk("stall_hold", {outValid, outByte}, {1'b1, prev});
      if (rst_at >= 0 && nx == rst_at) begin
        #2 rst = 1'b0;
        #1 chk("rst_async", {outValid, busy, frameDone, overrun, outByte}, 0);
        return;
      end
      if (ovr_at >= 0 && nx == ovr_at && ph == 0) begin
        inValid = 1'b0;
        ph = 1;
      end else if (ph == 1) begin
        for (int i = 0; i < 64; i++) inFrame[18*i +: 18] = 18'($urandom);
        inValid = 1'b1;
        ph = 2;
      end
      outReady = ($urandom_range(99) < pct);
      if (outValid && outReady) begin
        if (expq.size() == 0) chk("extra_byte", expq.size(), 1);
        else begin
          e = expq.pop_front();
          chk("byte", outByte, e);
        end
        if (c_first < 0) c_first = cyc;
        c_last = cyc;
        nx++;
      end
      hold = outValid && !outReady;
      prev = outByte;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic idle_check(input string tag);
    int seen = 0;
    outReady = 1'b1;
    repeat (10) begin
      @(negedge clk);
      seen += int'(outValid | frameDone | busy);
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    int nx, cf, cl;
    bit gd;
    rst = 1'b0; inValid = 1'b0; outReady = 1'b0; inFrame = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {outValid, busy, frameDone, overrun, outByte}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Ramp frame, full rate, inValid held high afterwards.
    for (int i = 0; i < 64; i++) smp[i] = 18'(i);
    build_exp();
    start_frame(1'b1);
    run_frame(100, -1, -1, nx, cf, cl, gd);
    chk("ramp_done", gd, 1);
    chk("ramp_count", nx, 193);
    chk("ramp_no_bubble", cl - cf, 192);
    chk("ramp_queue_empty", expq.size(), 0);
    idle_check("ramp_no_restart");

    // Sign and width corners.
    rand_frame();
    smp[0] = 18'h20000; smp[1] = 18'h1FFFF; smp[2] = 18'h3FFFF;
    build_exp();
    start_frame(1'b1);
    run_frame(100, -1, -1, nx, cf, cl, gd);
    chk("corner_done", gd, 1);
    chk("corner_count", nx, 193);

    // Back-pressure, about 30% ready.
    rand_frame();
    build_exp();
    start_frame(1'b1);
    run_frame(30, -1, -1, nx, cf, cl, gd);
    chk("bp_done", gd, 1);
    chk("bp_count", nx, 193);
    idle_check("bp_single_done");

    // Overrun: re-edge at byte 50 with a different frame.
    rand_frame();
    build_exp();
    start_frame(1'b1);
    chk("ovr_clear_pre", overrun, 0);
    run_frame(70, 50, -1, nx, cf, cl, gd);
    chk("ovr_done", gd, 1);
    chk("ovr_count", nx, 193);
    chk("ovr_flag", overrun, 1);
    idle_check("ovr_no_second");
    chk("ovr_sticky", overrun, 1);

    // Asynchronous reset at byte 100, inValid still high.
    rand_frame();
    build_exp();
    start_frame(1'b1);
    run_frame(100, -1, 100, nx, cf, cl, gd);
    @(negedge clk);
    rst = 1'b1;
    build_exp();
    @(negedge clk);
    chk("rst_restart_vld", outValid, 1);
    chk("rst_restart_hdr", outByte, 8'hA5);
    chk("rst_ovr_clear", overrun, 0);
    run_frame(100, -1, -1, nx, cf, cl, gd);
    chk("rst_frame_done", gd, 1);
    chk("rst_frame_count", nx, 193);

    // Back-to-back: second edge on the frameDone cycle.
    rand_frame();
    build_exp();
    start_frame(1'b1);
    inValid = 1'b0;
    run_frame(100, -1, -1, nx, cf, cl, gd);
    chk("b2b1_done", gd, 1);
    chk("b2b1_count", nx, 193);
    rand_frame();
    build_exp();
    pack();
    inValid = 1'b1;
    @(negedge clk);
    chk("b2b2_start_vld", outValid, 1);
    chk("b2b2_start_hdr", outByte, 8'hA5);
    chk("b2b2_done_pulse", frameDone, 0);
    run_frame(60, -1, -1, nx, cf, cl, gd);
    chk("b2b2_done", gd, 1);
    chk("b2b2_count", nx, 193);
    chk("b2b_no_overrun", overrun, 0);

    $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
    $finish;
  end
endmodule
